hilo_muldiv_unit: RTL and testbench
===================================

# hilo_muldiv_unit

Multi-cycle integer multiply/divide unit that sits directly upstream of the HI/LO register pair in the datapath. It executes MULT, MULTU, DIV, DIVU, MADD, MSUB, MTHI and MTLO. It presents the 64-bit result as separate HI/LO words with a one-cycle Done strobe, which the HI/LO register stage uses as its write qualifier. The iterative radix-2 engine trades latency for area; the pipeline control stalls on Busy.

## Interface
- Parameters:
  - XLEN, 32, operand width; HI/LO are XLEN each.
  - ITER, XLEN, number of shift/add or shift/subtract iterations.
- Ports:
  - Clk  in  1  single clock; all state updates on posedge.
  - Rst  in  1  reset, synchronous and active-high.
  - Start  in  1  request; sampled only in IDLE.
  - Op  in  3  operation code (see package).
  - A  in  XLEN  rs operand (multiplicand, dividend, or MTHI/MTLO source).
  - B  in  XLEN  rt operand (multiplier or divisor).
  - HI_cur, LO_cur  in  XLEN  current HI/LO register outputs; used by MADD/MSUB/MTHI/MTLO.
  - HI_result, LO_result  out  XLEN  result words; held until the next accepted Start.
  - Busy  out  1  operation in progress; the pipeline stalls on it.
  - Done  out  1  one-cycle pulse; results are valid and the HI/LO register writes.

## Operation
- FSM states are IDLE, CALC, FIX and DONE.
  - IDLE: when Start=1, latch Op, |A|, |B|, the sign flags and {HI_cur,LO_cur}, then go to CALC.
  - MTHI/MTLO and divide-by-zero skip CALC and go directly to DONE.
- CALC runs ITER iterations with an iteration counter of width clog2(ITER+1).
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring shift-subtract on magnitudes, producing a quotient and a remainder.
- FIX applies sign correction, then the accumulate step.
  - MULT/MADD/MSUB: the product is negative when sign(A) xor sign(B).
  - DIV: the quotient is negated when sign(A) xor sign(B); the remainder takes sign(A), i.e. truncation toward zero.
  - MADD: {HI,LO} = latched {HI_cur,LO_cur} + product, mod 2^64.
  - MSUB: {HI,LO} = latched {HI_cur,LO_cur} − product, mod 2^64.
- Result mapping:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
  - MTHI: HI = A, LO = latched LO_cur.
  - MTLO: LO = A, HI = latched HI_cur.
- Divide by zero (DIV or DIVU with B=0): HI = A, LO = all-ones.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0; natural wrap, no trap.
- Start while not IDLE is ignored and not queued.
- Unused Op codes complete as MTHI/MTLO timing with HI and LO unchanged (latched values).

## Timing
- Start is accepted on edge 0.
- Multiply/divide path: CALC occupies edges 1..ITER; FIX is edge ITER+1; DONE is edge ITER+2, giving Done high during cycle 34 at XLEN=32.
- MTHI/MTLO/div-by-zero path: Done is high in cycle 1, the cycle after acceptance.
- Busy is 1 in CALC and FIX, and 0 in IDLE and DONE.
- Done is 1 only in DONE; the FSM then returns to IDLE.
- A new Start may be accepted in the cycle after DONE.
- HI_result/LO_result change only on the DONE-entry edge, so they are stable for the whole Done cycle and for both clock edges.
- Reset values: HI_result = 0, LO_result = 0, Busy = 0, Done = 0, FSM in IDLE, counter 0.
- Reset mid-operation aborts on that edge. No Done is produced, and outputs return to their reset values.
- Reset has priority over Start in the same cycle.

## Structure
- Shared package `muldiv_pkg` holds:
  - the Op encoding: MULT=0, MULTU=1, DIV=2, DIVU=3, MADD=4, MSUB=5, MTHI=6, MTLO=7;
  - the FSM state enum;
  - XLEN.
- One natural sub-module, `muldiv_sign_fix`: combinational magnitude extraction and final negation/accumulate. It is shared by the entry and FIX logic.
- The shift registers (64-bit acc/remainder:quotient), counter and FSM stay in the top module.

## Test plan
- MULT A=0xFFFFFFFD (−3), B=7 → Done in cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFEB; Busy high for cycles 1..33.
- DIVU A=100, B=7 → LO=14, HI=2.
- DIV A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=5, B=0 → Done in cycle 1; HI=5, LO=0xFFFFFFFF.
- MADD with HI_cur=0, LO_cur=0xFFFFFFFF, A=1, B=1 → HI=1, LO=0.
- MULTU started, Start re-pulsed in cycle 5 (ignored), Rst in cycle 10 → Busy=0, outputs 0, no Done.
- Then MTLO A=0x1234 with HI_cur=0xAA → Done in cycle 1; LO=0x1234, HI=0xAA.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  // Operations whose operands are treated as two's complement
  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Magnitude extraction on entry and sign correction / accumulate on exit.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = muldiv_pkg::XLEN
) (
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              is_signed,
  output logic [XLEN-1:0]   mag_a_c,
  output logic [XLEN-1:0]   mag_b_c,
  output logic              sign_a_c,
  output logic              sign_b_c,
  input  op_e               op,
  input  logic              neg_a,
  input  logic              neg_b,
  input  logic [2*XLEN-1:0] raw,
  input  logic [2*XLEN-1:0] hilo,
  output logic [2*XLEN-1:0] res_c
);

  localparam int unsigned DW = 2 * XLEN;

  logic [DW-1:0]   prod;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;

  // Operand signs and absolute values for the unsigned engine
  always_comb begin
    sign_a_c = is_signed & a[XLEN-1];
    sign_b_c = is_signed & b[XLEN-1];
    mag_a_c  = sign_a_c ? (XLEN'(0) - a) : a;
    mag_b_c  = sign_b_c ? (XLEN'(0) - b) : b;
  end

  // Re-apply signs to the engine result, then accumulate into HI/LO if asked
  always_comb begin
    prod  = (neg_a ^ neg_b) ? (DW'(0) - raw) : raw;
    quot  = (neg_a ^ neg_b) ? (XLEN'(0) - raw[XLEN-1:0]) : raw[XLEN-1:0];
    rem   = neg_a ? (XLEN'(0) - raw[DW-1:XLEN]) : raw[DW-1:XLEN];
    res_c = hilo;
    case (op)
      OP_MULT, OP_MULTU: res_c = prod;
      OP_MADD:           res_c = hilo + prod;
      OP_MSUB:           res_c = hilo - prod;
      OP_DIV, OP_DIVU:   res_c = {rem, quot};
      default:           res_c = hilo;
    endcase
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit feeding the HI/LO register pair.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = muldiv_pkg::XLEN,
  parameter int unsigned ITER = XLEN
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Start,
  input  logic [OP_W-1:0] Op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [XLEN-1:0] HI_cur,
  input  logic [XLEN-1:0] LO_cur,
  output logic [XLEN-1:0] HI_result,
  output logic [XLEN-1:0] LO_result,
  output logic            Busy,
  output logic            Done
);

  localparam int unsigned DW    = 2 * XLEN;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  state_e            state_q, state_nxt;
  logic              busy_nxt, done_nxt;
  logic [CNT_W-1:0]  cnt_q;
  op_e               op_q;
  logic              neg_a_q, neg_b_q;
  logic [XLEN-1:0]   mag_a_q, mag_b_q;
  logic [DW-1:0]     hilo_q;
  logic [DW-1:0]     acc_q;

  op_e               op_in;
  logic              is_signed_c;
  logic              fast_c;
  logic              last_iter_c;
  logic [XLEN-1:0]   mag_a_c, mag_b_c;
  logic              sign_a_c, sign_b_c;
  logic [DW-1:0]     fix_res_c;
  logic [DW-1:0]     fast_res_c;
  logic [XLEN:0]     mul_sum_c;
  logic [XLEN:0]     rem_sh_c;
  logic [XLEN:0]     diff_c;
  logic [DW-1:0]     step_c;

  assign op_in       = op_e'(Op);
  assign is_signed_c = is_signed_op(op_in);
  assign fast_c      = (op_in == OP_MTHI) || (op_in == OP_MTLO) ||
                       (is_div_op(op_in) && (B == '0));
  assign last_iter_c = (cnt_q == CNT_W'(ITER - 1));

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .a         (A),
    .b         (B),
    .is_signed (is_signed_c),
    .mag_a_c   (mag_a_c),
    .mag_b_c   (mag_b_c),
    .sign_a_c  (sign_a_c),
    .sign_b_c  (sign_b_c),
    .op        (op_q),
    .neg_a     (neg_a_q),
    .neg_b     (neg_b_q),
    .raw       (acc_q),
    .hilo      (hilo_q),
    .res_c     (fix_res_c)
  );

  // Results for operations that bypass the iterative engine
  always_comb begin
    fast_res_c = {HI_cur, LO_cur};
    case (op_in)
      OP_MTHI:         fast_res_c = {A, LO_cur};
      OP_MTLO:         fast_res_c = {HI_cur, A};
      OP_DIV, OP_DIVU: fast_res_c = {A, {XLEN{1'b1}}};
      default:         fast_res_c = {HI_cur, LO_cur};
    endcase
  end

  // One shift-add or restoring shift-subtract step on the shared accumulator
  always_comb begin
    mul_sum_c = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    rem_sh_c  = {acc_q[DW-1:XLEN], acc_q[XLEN-1]};
    diff_c    = rem_sh_c - {1'b0, mag_b_q};
    step_c    = {mul_sum_c, acc_q[XLEN-1:1]};
    if (is_div_op(op_q)) begin
      if (!diff_c[XLEN]) begin
        step_c = {diff_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        step_c = {rem_sh_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt = state_q;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state_q)
      S_IDLE:  if (Start) state_nxt = fast_c ? S_DONE : S_CALC;
      S_CALC:  if (last_iter_c) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt == S_CALC) || (state_nxt == S_FIX);
    done_nxt = (state_nxt == S_DONE);
  end

  // State register with registered Busy/Done
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      Busy    <= busy_nxt;
      Done    <= done_nxt;
    end
  end

  // Operand capture, iteration and result write-back
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q     <= '0;
      op_q      <= OP_MULT;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      hilo_q    <= '0;
      acc_q     <= '0;
      HI_result <= '0;
      LO_result <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            op_q    <= op_in;
            neg_a_q <= sign_a_c;
            neg_b_q <= sign_b_c;
            mag_a_q <= mag_a_c;
            mag_b_q <= mag_b_c;
            hilo_q  <= {HI_cur, LO_cur};
            cnt_q   <= '0;
            acc_q   <= is_div_op(op_in) ? {XLEN'(0), mag_a_c} : {XLEN'(0), mag_b_c};
            if (fast_c) begin
              {HI_result, LO_result} <= fast_res_c;
            end
          end
        end
        S_CALC: begin
          acc_q <= step_c;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_FIX: begin
          {HI_result, LO_result} <= fix_res_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized self-checking bench for hilo_muldiv_unit against an arithmetic reference.
module tb_hilo_muldiv_unit;

  localparam int unsigned SLOW_LAT = 34;
  localparam int unsigned MAX_CYC  = 200;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] HI_cur = '0;
  logic [31:0] LO_cur = '0;
  logic [31:0] HI_result;
  logic [31:0] LO_result;
  logic        Busy;
  logic        Done;

  int n_chk = 0;
  int n_err = 0;

  hilo_muldiv_unit dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .HI_cur    (HI_cur),
    .LO_cur    (LO_cur),
    .HI_result (HI_result),
    .LO_result (LO_result),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result of one operation, from plain 64-bit arithmetic
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p_s, p_u;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    p_s = sa * sb;
    p_u = {32'd0, a} * {32'd0, b};
    case (op)
      3'd0: return p_s;
      3'd1: return p_u;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd4: return {hi, lo} + p_s;
      3'd5: return {hi, lo} - p_s;
      3'd6: return {a, lo};
      default: return {hi, a};
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
    if (op == 3'd6 || op == 3'd7) return 1;
    if ((op == 3'd2 || op == 3'd3) && b == 32'd0) return 1;
    return int'(SLOW_LAT);
  endfunction

  // Issue one operation, scramble inputs and re-pulse Start while busy, then check everything
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] exp_res, prev_res;
    int          exp_lat, cyc, busy_bad, hold_bad;
    exp_res  = ref_result(op, a, b, hi, lo);
    exp_lat  = ref_latency(op, b);
    busy_bad = 0;
    hold_bad = 0;
    @(negedge Clk);
    prev_res = {HI_result, LO_result};
    Op = op; A = a; B = b; HI_cur = hi; LO_cur = lo; Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    Op = 3'($urandom); A = $urandom; B = $urandom; HI_cur = $urandom; LO_cur = $urandom;
    cyc = 1;
    while (!Done && cyc < int'(MAX_CYC)) begin
      if (!Busy) busy_bad++;
      if ({HI_result, LO_result} !== prev_res) hold_bad++;
      @(posedge Clk);
      #1;
      cyc++;
      Start = (cyc == 5);
      if (cyc == 5) Op = 3'($urandom);
    end
    Start = 1'b0;
    check_eq({name, " latency"}, 64'(cyc), 64'(exp_lat));
    check_eq({name, " hilo"}, {HI_result, LO_result}, exp_res);
    check_eq({name, " busy_in_done"}, 64'(Busy), 64'(0));
    if (exp_lat > 1) begin
      check_eq({name, " busy_during_op"}, 64'(busy_bad), 64'(0));
      check_eq({name, " result_hold"}, 64'(hold_bad), 64'(0));
    end
    @(negedge Clk);
    check_eq({name, " done_stable_hilo"}, {HI_result, LO_result}, exp_res);
    @(posedge Clk);
    #1;
    check_eq({name, " done_pulse"}, 64'(Done), 64'(0));
    check_eq({name, " held_hilo"}, {HI_result, LO_result}, exp_res);
  endtask

  initial begin
    int done_cnt, busy_cnt, sel;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;

    repeat (3) @(posedge Clk);
    #1;
    check_eq("reset hi", 64'(HI_result), 64'(0));
    check_eq("reset lo", 64'(LO_result), 64'(0));
    check_eq("reset busy", 64'(Busy), 64'(0));
    check_eq("reset done", 64'(Done), 64'(0));
    Rst = 1'b0;

    run_op("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0);
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'h1, 32'h2);
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0);
    run_op("div_by_zero", 3'd2, 32'd5, 32'd0, 32'h55, 32'h66);
    run_op("madd_carry", 3'd4, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
    run_op("div_overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h9, 32'h9);
    run_op("divu_by_zero", 3'd3, 32'hDEAD_BEEF, 32'd0, 32'h1, 32'h1);
    run_op("msub", 3'd5, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd10);

    // Reset in the middle of a multiply aborts it
    @(negedge Clk);
    Op = 3'd1; A = 32'h1234_5678; B = 32'h9ABC_DEF0; Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      @(posedge Clk);
      #1;
      Start = (c == 5);
      Rst   = (c == 10);
    end
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    check_eq("abort busy", 64'(Busy), 64'(0));
    check_eq("abort done", 64'(Done), 64'(0));
    check_eq("abort hilo", {HI_result, LO_result}, 64'(0));
    done_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge Clk);
      #1;
      if (Done) done_cnt++;
      if (Busy) busy_cnt++;
    end
    check_eq("abort no_done", 64'(done_cnt), 64'(0));
    check_eq("abort no_busy", 64'(busy_cnt), 64'(0));

    run_op("mtlo", 3'd7, 32'h0000_1234, 32'h0, 32'hAA, 32'h77);
    run_op("mthi", 3'd6, 32'hCAFE_F00D, 32'h0, 32'hAA, 32'h77);

    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      sel  = int'($urandom_range(0, 7));
      if (sel == 0) r_b = 32'd0;
      else if (sel == 1) begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
      else if (sel == 2) r_b = 32'($urandom_range(1, 15));
      run_op($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
